// File: rtl/pulse_monitor_pkg.sv
// Shared constants and types for the pulse monitor.
// Covers the frame length, the statistic widths and the output FSM encoding.
package pulse_monitor_pkg;

    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = 4;
    localparam int ONES_W    = 5;
    localparam int RISE_W    = 4;
    localparam int RUN_W     = 5;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    function automatic logic [RUN_W-1:0] max_of(input logic [RUN_W-1:0] a,
                                                input logic [RUN_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_monitor_if.sv
// Result channel of the pulse monitor.
// Carries the completed word, its statistics and the valid/ready handshake.
interface pulse_monitor_if;
    import pulse_monitor_pkg::*;

    logic [FRAME_LEN-1:0] word_out;
    logic [ONES_W-1:0]    ones_count;
    logic [RISE_W-1:0]    rise_count;
    logic [RUN_W-1:0]     max_run;
    logic                 word_valid;
    logic                 word_ready;

    modport master (
        output word_out,
        output ones_count,
        output rise_count,
        output max_run,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  ones_count,
        input  rise_count,
        input  max_run,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/frame_stats_acc.sv
// Per-bit accumulator for ones, 0->1 rises and the longest run of ones in a frame.
// Asserting first restarts every statistic from the current bit alone.
module frame_stats_acc
    import pulse_monitor_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pulse_bit,
    input  logic              first,
    input  logic              step,
    output logic [ONES_W-1:0] ones,
    output logic [RISE_W-1:0] rise,
    output logic [RUN_W-1:0]  max_run
);

    logic             prev_bit;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] next_run;

    always_comb begin
        next_run = '0;
        if (first) begin
            next_run = RUN_W'(pulse_bit);
        end else if (pulse_bit) begin
            next_run = run + RUN_W'(1);
        end
    end

    // A rise needs a previous bit inside the same frame, so the first bit never counts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ones     <= '0;
            rise     <= '0;
            max_run  <= '0;
            run      <= '0;
            prev_bit <= 1'b0;
        end else if (step) begin
            if (first) begin
                ones    <= ONES_W'(pulse_bit);
                rise    <= '0;
                max_run <= next_run;
            end else begin
                ones    <= ones + ONES_W'(pulse_bit);
                rise    <= rise + RISE_W'(pulse_bit & ~prev_bit);
                max_run <= max_of(max_run, next_run);
            end
            run      <= next_run;
            prev_bit <= pulse_bit;
        end
    end

endmodule

// File: rtl/pulse_monitor.sv
// Assembles 16-bit MSB-first frames from a serial pulse stream.
// Each completed frame and its statistics are offered one cycle later on a valid/ready channel.
module pulse_monitor
    import pulse_monitor_pkg::*;
#(
    parameter int WIDTH = FRAME_LEN
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic sync,
    input  logic pulse_in,
    input  logic clear_overrun,
    output logic overrun,
    pulse_monitor_if.master res
);

    logic [WIDTH-1:0]  shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              frame_done;
    logic              first_bit;
    logic              transfer;
    logic              take_word;
    logic              drop_word;
    logic [ONES_W-1:0] acc_ones;
    logic [RISE_W-1:0] acc_rise;
    logic [RUN_W-1:0]  acc_max_run;
    out_state_t        state;

    assign first_bit      = sync || (bit_cnt == '0);
    assign transfer       = res.word_valid && res.word_ready;
    assign take_word      = frame_done && ((state == EMPTY) || transfer);
    assign drop_word      = frame_done && (state == FULL) && !transfer;
    assign res.word_valid = (state == FULL);

    // frame_done marks the cycle after the last bit, when shift and the accumulators hold the full frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= enable && !sync && (bit_cnt == LAST_BIT);
            if (enable) begin
                if (sync) begin
                    shift   <= {{(WIDTH-1){1'b0}}, pulse_in};
                    bit_cnt <= CNT_W'(1);
                end else begin
                    shift   <= {shift[WIDTH-2:0], pulse_in};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    frame_stats_acc u_stats (
        .clock     (clock),
        .reset_n   (reset_n),
        .pulse_bit (pulse_in),
        .first     (first_bit),
        .step      (enable),
        .ones      (acc_ones),
        .rise      (acc_rise),
        .max_run   (acc_max_run)
    );

    // Output holder: a finished frame is taken when the slot is empty or being emptied on the same edge, otherwise it is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= EMPTY;
            res.word_out   <= '0;
            res.ones_count <= '0;
            res.rise_count <= '0;
            res.max_run    <= '0;
            overrun        <= 1'b0;
        end else begin
            if (take_word) begin
                res.word_out   <= shift;
                res.ones_count <= acc_ones;
                res.rise_count <= acc_rise;
                res.max_run    <= acc_max_run;
            end

            if (drop_word) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                EMPTY: begin
                    if (take_word) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (transfer && !frame_done) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed self-checking bench for pulse_monitor.
// Drives inputs on the falling edge and samples outputs there, half a cycle after each active edge.
module tb_pulse_monitor;

    logic clock;
    logic reset_n;
    logic enable;
    logic sync;
    logic pulse_in;
    logic clear_overrun;
    logic overrun;

    int cmp_count  = 0;
    int fail_count = 0;

    pulse_monitor_if mon ();

    pulse_monitor #(.WIDTH(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .sync          (sync),
        .pulse_in      (pulse_in),
        .clear_overrun (clear_overrun),
        .overrun       (overrun),
        .res           (mon)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        cmp_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] word,
                                input int ones, input int rise, input int run);
        check_output({tag, ".word"}, 32'(mon.word_out), 32'(word));
        check_output({tag, ".ones"}, 32'(mon.ones_count), 32'(ones));
        check_output({tag, ".rise"}, 32'(mon.rise_count), 32'(rise));
        check_output({tag, ".run"},  32'(mon.max_run), 32'(run));
        check_output({tag, ".valid"}, 32'(mon.word_valid), 32'd1);
    endtask

    task automatic apply_stimulus(input logic b, input logic s);
        pulse_in = b;
        sync     = s;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_range(input logic [15:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            apply_stimulus(w[i], 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic s);
        apply_stimulus(w[15], s);
        send_range(w, 14, 0);
    endtask

    initial begin
        reset_n       = 1'b1;
        enable        = 1'b0;
        sync          = 1'b0;
        pulse_in      = 1'b0;
        clear_overrun = 1'b0;
        mon.word_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_output("rst.word",    32'(mon.word_out), 32'd0);
        check_output("rst.ones",    32'(mon.ones_count), 32'd0);
        check_output("rst.rise",    32'(mon.rise_count), 32'd0);
        check_output("rst.run",     32'(mon.max_run), 32'd0);
        check_output("rst.valid",   32'(mon.word_valid), 32'd0);
        check_output("rst.overrun", 32'(overrun), 32'd0);

        @(negedge clock);
        reset_n        = 1'b1;
        enable         = 1'b1;
        mon.word_ready = 1'b1;

        // Aligned A5F0 frame, then a free-running repeat.
        send_frame(16'hA5F0, 1'b1);
        check_output("a5f0.latency", 32'(mon.word_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0);
        check_result("a5f0", 16'hA5F0, 8, 3, 5);
        check_output("a5f0.overrun", 32'(overrun), 32'd0);
        send_range(16'hA5F0, 14, 14);
        check_output("a5f0.one_cycle", 32'(mon.word_valid), 32'd0);
        send_range(16'hA5F0, 13, 0);
        apply_stimulus(1'b1, 1'b0);
        check_output("repeat.word",  32'(mon.word_out), 32'h0000A5F0);
        check_output("repeat.valid", 32'(mon.word_valid), 32'd1);

        send_range(16'hFFFF, 14, 0);
        apply_stimulus(1'b0, 1'b0);
        check_result("ffff", 16'hFFFF, 16, 0, 16);

        send_range(16'h0000, 14, 0);
        apply_stimulus(1'b0, 1'b0);
        check_result("zero", 16'h0000, 0, 0, 0);

        send_range(16'h5555, 14, 0);
        mon.word_ready = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        check_result("5555", 16'h5555, 8, 8, 1);

        // Consumer stalled: the next completed frame must be dropped.
        send_range(16'h3C3C, 14, 0);
        check_output("stall.no_ovr_yet", 32'(overrun), 32'd0);
        apply_stimulus(1'b0, 1'b0);
        check_output("stall.overrun", 32'(overrun), 32'd1);
        check_output("stall.held",    32'(mon.word_out), 32'h00005555);
        clear_overrun = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        clear_overrun = 1'b0;
        check_output("clear.overrun", 32'(overrun), 32'd0);
        check_output("clear.held",    32'(mon.word_out), 32'h00005555);
        check_output("clear.valid",   32'(mon.word_valid), 32'd1);
        send_range(16'h3C3C, 13, 0);
        clear_overrun = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        clear_overrun = 1'b0;
        check_output("clr_vs_set.overrun", 32'(overrun), 32'd1);
        check_output("clr_vs_set.held",    32'(mon.ones_count), 32'd8);

        // Transfer coinciding with a new load.
        clear_overrun = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        clear_overrun = 1'b0;
        send_range(16'h0F0F, 13, 0);
        mon.word_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        mon.word_ready = 1'b0;
        check_result("swap", 16'h0F0F, 8, 2, 4);
        check_output("swap.overrun", 32'(overrun), 32'd0);
        apply_stimulus(1'b0, 1'b0);
        check_output("swap.hold_valid", 32'(mon.word_valid), 32'd1);
        check_output("swap.hold_word",  32'(mon.word_out), 32'h00000F0F);

        // Resync at bit_cnt 7 discards the partial frame.
        mon.word_ready = 1'b1;
        send_range(16'hA5F0, 13, 9);
        check_output("drain.valid", 32'(mon.word_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1);
        send_range(16'h1234, 14, 6);
        check_output("sync.discard", 32'(mon.word_valid), 32'd0);
        mon.word_ready = 1'b0;
        send_range(16'h1234, 5, 0);
        check_output("sync.latency", 32'(mon.word_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0);
        check_result("sync", 16'h1234, 5, 4, 2);

        // Asynchronous reset mid-frame while holding a word.
        apply_stimulus(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_output("arst.word",    32'(mon.word_out), 32'd0);
        check_output("arst.ones",    32'(mon.ones_count), 32'd0);
        check_output("arst.rise",    32'(mon.rise_count), 32'd0);
        check_output("arst.run",     32'(mon.max_run), 32'd0);
        check_output("arst.valid",   32'(mon.word_valid), 32'd0);
        check_output("arst.overrun", 32'(overrun), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Restart from bit 0 without sync, with a frozen stretch in the middle.
        send_range(16'hA5F0, 15, 8);
        enable   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1);
        end
        enable = 1'b1;
        sync   = 1'b0;
        send_range(16'hA5F0, 7, 0);
        check_output("restart.latency", 32'(mon.word_valid), 32'd0);
        apply_stimulus(1'b0, 1'b0);
        check_result("restart", 16'hA5F0, 8, 3, 5);

        // Transfers still complete while sampling is frozen.
        enable         = 1'b0;
        mon.word_ready = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        check_output("frozen.transfer", 32'(mon.word_valid), 32'd0);
        mon.word_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
